i2c_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one `i2c_master` between `NUM_REQ` requesters (APB register banks, sensor pollers).
- Grants one requester at a time and latches its descriptor (address, rw, repeat-start).
- Launches the master, routes the master's tx-byte pops and rx-byte writes to the granted requester, and reports completion or timeout.
- Sits between the requester logic and the master's core/FIFO-control pins.

---
 rtl/i2c_arbiter_if.sv | 37 +++
 rtl/i2c_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: command and FIFO-strobe pins between the arbiter
// and the shared i2c_master core.
interface i2c_arbiter_if;
    logic [6:0] m_addr;
    logic       m_rw;
    logic       m_repeat_start;
    logic       m_enable;
    logic [7:0] m_data_in;
    logic       m_ready;
    logic [7:0] m_data_out;
    logic       m_tx_rd_en;
    logic       m_rx_wr_en;

    modport master (
        output m_addr,
        output m_rw,
        output m_repeat_start,
        output m_enable,
        output m_data_in,
        input  m_ready,
        input  m_data_out,
        input  m_tx_rd_en,
        input  m_rx_wr_en
    );

    modport slave (
        input  m_addr,
        input  m_rw,
        input  m_repeat_start,
        input  m_enable,
        input  m_data_in,
        output m_ready,
        output m_data_out,
        output m_tx_rd_en,
        output m_rx_wr_en
    );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c_master among NUM_REQ
// requesters, with byte routing, completion and timeout reporting.
module i2c_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 i2c_reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ-1:0]   req_repeat_start,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   wdata_pop,
    output logic [7:0]           rdata,
    output logic [NUM_REQ-1:0]   rdata_valid,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    i2c_arbiter_if.master        bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] last;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          to_err;
    logic          tx_q;
    logic          rx_q;
    logic          tx_rise;
    logic          rx_rise;
    logic [6:0]    addr_q;
    logic          rw_q;
    logic          rs_q;
    logic [7:0]    wmux;

    assign tx_rise = bus.m_tx_rd_en & ~tx_q;
    assign rx_rise = bus.m_rx_wr_en & ~rx_q;

    assign bus.m_addr         = addr_q;
    assign bus.m_rw           = rw_q;
    assign bus.m_repeat_start = rs_q;
    assign bus.m_enable       = (state == LAUNCH);
    assign bus.m_data_in      = wmux;

    assign done = (state == DONE) ? gnt : '0;
    assign err  = (state == DONE) & err_q;

    // Round-robin search: first requester after the last one served.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req[(int'(last) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    // Write byte of the granted requester; zero while nothing is granted.
    always_comb begin
        wmux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wmux = wmux | req_wdata[8*i +: 8];
            end
        end
    end

    // Transaction sequencing and timeout detection.
    always_comb begin
        state_next = state;
        to_err     = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found && bus.m_ready) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!bus.m_ready) begin
                    state_next = BUSY;
                end else if (cnt == TO_MAX) begin
                    state_next = DONE;
                    to_err     = 1'b1;
                end
            end
            BUSY: begin
                if (bus.m_ready) begin
                    state_next = DONE;
                end else if (cnt == TO_MAX) begin
                    state_next = DONE;
                    to_err     = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, grant, descriptor latch, strobe edges and timeout counter.
    always_ff @(posedge clk) begin
        if (i2c_reset) begin
            state       <= IDLE;
            last        <= LAST_RST;
            gnt         <= '0;
            gnt_idx     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            rs_q        <= 1'b0;
            cnt         <= '0;
            err_q       <= 1'b0;
            tx_q        <= 1'b0;
            rx_q        <= 1'b0;
            wdata_pop   <= '0;
            rdata_valid <= '0;
            rdata       <= '0;
        end else begin
            state <= state_next;
            tx_q  <= bus.m_tx_rd_en;
            rx_q  <= bus.m_rx_wr_en;

            wdata_pop   <= (state == BUSY && tx_rise) ? gnt : '0;
            rdata_valid <= (state == BUSY && rx_rise) ? gnt : '0;
            if (state == BUSY && rx_rise) begin
                rdata <= bus.m_data_out;
            end

            if (state_next != state) begin
                cnt <= '0;
            end else if (state == BUSY && (tx_rise || rx_rise)) begin
                cnt <= '0;
            end else if (cnt != TO_MAX) begin
                cnt <= cnt + CW'(1);
            end

            if (state == IDLE && state_next == LAUNCH) begin
                gnt     <= ONE << win_idx;
                gnt_idx <= win_idx;
                addr_q  <= req_addr[7*int'(win_idx) +: 7];
                rw_q    <= req_rw[win_idx];
                rs_q    <= req_repeat_start[win_idx];
            end

            if (state == DONE) begin
                gnt  <= '0;
                last <= gnt_idx;
            end

            if (to_err) begin
                err_q <= 1'b1;
            end else if (state == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule
